// File: rtl/bit_enum_if.sv
// Handshake bundle for the set-bit enumerator: word input side and beat output side.
interface bit_enum_if #(
  parameter int ORDER = 3
);
  localparam int W = 2**ORDER;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [ORDER-1:0] out_index;
  logic [ORDER:0]   out_rank;
  logic             out_last;
  logic             out_empty;

  // Producer of words / consumer of beats.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_index, out_rank, out_last, out_empty
  );

  // The enumerator itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_index, out_rank, out_last, out_empty
  );
endinterface

// File: rtl/bit_enum.sv
// Set-bit enumerator: takes a W-bit mask and emits the index of every set bit,
// lowest first, one beat per cycle, each beat tagged with its running rank.
// All out_* come from registers; only in_ready looks through to out_ready.
module bit_enum #(
  parameter int ORDER = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  bit_enum_if.slave bus
);
  localparam int W = 2**ORDER;

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [W-1:0]     mask_reg, mask_next;
  logic [ORDER:0]   rank_reg, rank_next;

  logic [W-1:0]     below;       // below[i] = some bit under position i is set
  logic [W-1:0]     low_onehot;  // isolates the lowest pending bit
  logic [ORDER-1:0] low_index;
  logic             mask_any;
  logic             mask_single; // at most one bit pending -> this beat is the last

  // Prefix-OR chain picks out the lowest set bit as a one-hot vector.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_low
      if (gi == 0) begin : g_first
        assign below[gi] = 1'b0;
      end else begin : g_rest
        assign below[gi] = below[gi-1] | mask_reg[gi-1];
      end
      assign low_onehot[gi] = mask_reg[gi] & ~below[gi];
    end
  endgenerate

  assign mask_any    = |mask_reg;
  assign mask_single = ((mask_reg & (mask_reg - W'(1))) == '0);

  // Encode the one-hot lowest bit; OR-ing is safe because at most one bit is hot.
  always_comb begin
    low_index = '0;
    for (int i = 0; i < W; i++) begin
      if (low_onehot[i]) begin
        low_index = low_index | ORDER'(i);
      end
    end
  end

  // State register: pending mask, rank so far, and FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      mask_reg  <= '0;
      rank_reg  <= '0;
    end else begin
      state_reg <= state_next;
      mask_reg  <= mask_next;
      rank_reg  <= rank_next;
    end
  end

  // Next-state logic: load a word, retire one bit per accepted beat, chain words.
  always_comb begin
    state_next = state_reg;
    mask_next  = mask_reg;
    rank_next  = rank_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          mask_next  = bus.in_data;
          rank_next  = '0;
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          mask_next = mask_reg & ~low_onehot;
          rank_next = rank_reg + 1'b1;
          if (mask_single) begin
            if (bus.in_valid) begin
              // Next word follows the last beat with no idle cycle.
              mask_next = bus.in_data;
              rank_next = '0;
            end else begin
              state_next = IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode: beat fields purely from registers, in_ready also sees out_ready.
  always_comb begin
    bus.out_valid = (state_reg == EMIT);
    bus.out_index = low_index;
    bus.out_rank  = mask_any ? (rank_reg + 1'b1) : '0;
    bus.out_empty = ~mask_any;
    bus.out_last  = mask_single;
    bus.in_ready  = (state_reg == IDLE) |
                    ((state_reg == EMIT) & bus.out_ready & mask_single);
  end
endmodule

// File: tb/tb_bit_enum.sv
// Testbench for bit_enum: directed ORDER=3 vectors and sequences, plus a
// randomized ORDER=4 sweep, all checked against a beat scoreboard.
module tb_bit_enum;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bit_enum_if #(.ORDER(3)) b3();
  bit_enum_if #(.ORDER(4)) b4();

  bit_enum #(.ORDER(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  bit_enum #(.ORDER(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  typedef struct {
    logic [4:0] idx;
    logic [4:0] rank;
    logic       last;
    logic       empty;
  } beat_t;

  typedef struct {
    logic [7:0] data;
    int         beats;
    logic [4:0] lrank;
  } vec_t;

  beat_t       q3[$];
  beat_t       q4[$];
  logic [15:0] wq4[$];

  int n_checks = 0;
  int n_errors = 0;

  // ORDER=3 monitor state
  bit         stall3 = 1'b0;
  logic [2:0] s_idx;
  logic [3:0] s_rank;
  logic       s_last, s_empty;
  int         beats3 = 0;
  logic [4:0] last_rank3 = '0;
  bit         done3 = 1'b0;

  // ORDER=4 monitor state
  logic [15:0] recon4 = '0;
  int          done4 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: expected beat list for one accepted word.
  task automatic push_word(input logic [15:0] d, input int w, input bit sel);
    beat_t b;
    int k;
    int total;
    total = $countones(d);
    k = 0;
    if (d == 16'h0) begin
      b.idx = '0; b.rank = '0; b.last = 1'b1; b.empty = 1'b1;
      if (sel) q4.push_back(b); else q3.push_back(b);
    end else begin
      for (int i = 0; i < w; i++) begin
        if (d[i]) begin
          k++;
          b.idx = 5'(i); b.rank = 5'(k); b.last = (k == total); b.empty = 1'b0;
          if (sel) q4.push_back(b); else q3.push_back(b);
        end
      end
    end
  endtask

  // One cycle on the ORDER=3 instance: drive, sample at negedge, score.
  task automatic step3(input logic v, input logic [7:0] d, input logic r);
    beat_t e;
    logic  exp_rdy;
    b3.in_valid  = v;
    b3.in_data   = d;
    b3.out_ready = r;
    @(negedge clk);
    if (stall3) begin
      check("stall_hold",
            {b3.out_valid, b3.out_index, b3.out_rank, b3.out_last, b3.out_empty},
            {1'b1, s_idx, s_rank, s_last, s_empty});
    end
    exp_rdy = 1'b1;
    if (b3.out_valid) begin
      if (q3.size() == 0) check("spurious_beat3", 1, 0);
      else exp_rdy = r && q3[0].last;
    end
    check("in_ready3", b3.in_ready, exp_rdy);
    stall3 = b3.out_valid && !r;
    if (stall3) begin
      s_idx = b3.out_index; s_rank = b3.out_rank;
      s_last = b3.out_last; s_empty = b3.out_empty;
    end
    if (b3.in_valid && b3.in_ready) push_word({8'h00, d}, 8, 1'b0);
    if (b3.out_valid && r && q3.size() != 0) begin
      e = q3.pop_front();
      check("beat3",
            {2'b00, b3.out_index, 1'b0, b3.out_rank, b3.out_last, b3.out_empty},
            {e.idx, e.rank, e.last, e.empty});
      beats3++;
      if (b3.out_last) begin
        done3 = 1'b1;
        last_rank3 = {1'b0, b3.out_rank};
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Offer one word to an idle ORDER=3 block with out_ready high and run it out.
  task automatic run_word3(input logic [7:0] d, output int beats, output logic [4:0] lrank,
                           output int cycles);
    int n;
    beats3 = 0;
    done3  = 1'b0;
    step3(1'b1, d, 1'b1);
    n = 0;
    while (!done3 && n < 40) begin
      step3(1'b0, 8'h00, 1'b1);
      n++;
    end
    if (!done3) check("timeout3", 0, 1);
    beats  = beats3;
    lrank  = last_rank3;
    cycles = n;
  endtask

  // One cycle on the ORDER=4 instance with reconstruction of each word.
  task automatic step4(input logic v, input logic [15:0] d, input logic r);
    beat_t       e;
    logic [15:0] w;
    b4.in_valid  = v;
    b4.in_data   = d;
    b4.out_ready = r;
    @(negedge clk);
    if (b4.in_valid && b4.in_ready) begin
      push_word(d, 16, 1'b1);
      wq4.push_back(d);
    end
    if (b4.out_valid && r) begin
      if (q4.size() == 0) begin
        check("spurious_beat4", 1, 0);
      end else begin
        e = q4.pop_front();
        check("beat4",
              {1'b0, b4.out_index, b4.out_rank, b4.out_last, b4.out_empty},
              {e.idx, e.rank, e.last, e.empty});
      end
      if (!b4.out_empty) recon4 = recon4 | (16'd1 << b4.out_index);
      if (b4.out_last && wq4.size() != 0) begin
        w = wq4.pop_front();
        check("recon4", recon4, w);
        check("popcount4", b4.out_rank, $countones(w));
        $display("word4 #%0d data=%h indices=%h last_rank=%0d", done4, w, recon4, b4.out_rank);
        recon4 = '0;
        done4++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[7];

  initial begin
    int          beats, cycles, n;
    logic [4:0]  lrank;
    logic [15:0] d;

    vecs[0] = '{data: 8'b1010_0100, beats: 3, lrank: 5'd3};
    vecs[1] = '{data: 8'h00,        beats: 1, lrank: 5'd0};
    vecs[2] = '{data: 8'hFF,        beats: 8, lrank: 5'd8};
    vecs[3] = '{data: 8'h01,        beats: 1, lrank: 5'd1};
    vecs[4] = '{data: 8'h80,        beats: 1, lrank: 5'd1};
    vecs[5] = '{data: 8'h5A,        beats: 4, lrank: 5'd4};
    vecs[6] = '{data: 8'h02,        beats: 1, lrank: 5'd1};

    b3.in_valid = 1'b0; b3.in_data = '0; b3.out_ready = 1'b0;
    b4.in_valid = 1'b0; b4.in_data = '0; b4.out_ready = 1'b0;

    // Reset values
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_state3",
          {b3.out_valid, b3.in_ready, b3.out_index, b3.out_rank, b3.out_last, b3.out_empty},
          {1'b0, 1'b1, 3'd0, 4'd0, 1'b1, 1'b1});
    check("reset_state4",
          {b4.out_valid, b4.in_ready, b4.out_last, b4.out_empty},
          {1'b0, 1'b1, 1'b1, 1'b1});
    rst_n = 1'b1;

    // Table of single words, out_ready held high
    foreach (vecs[i]) begin
      run_word3(vecs[i].data, beats, lrank, cycles);
      check("beats", beats, vecs[i].beats);
      check("last_rank", lrank, vecs[i].lrank);
      check("cycles", cycles, vecs[i].beats);
      $display("word3 data=%h beats=%0d last_rank=%0d cycles=%0d",
               vecs[i].data, beats, lrank, cycles);
      step3(1'b0, 8'h00, 1'b1);
      check("idle_after", b3.out_valid, 1'b0);
    end

    // 0xFF with out_ready pattern 1,0,0,1,...
    beats3 = 0; done3 = 1'b0;
    step3(1'b1, 8'hFF, 1'b1);
    n = 0;
    while (!done3 && n < 60) begin
      step3(1'b0, 8'h00, (n % 4 == 0) || (n % 4 == 3));
      n++;
    end
    if (!done3) check("timeout_stall", 0, 1);
    check("stall_beats", beats3, 8);
    check("stall_last_rank", last_rank3, 8);
    $display("word3 data=ff stalled beats=%0d last_rank=%0d cycles=%0d", beats3, last_rank3, n);

    // Back-to-back 0x01 then 0x80, in_valid held high
    beats3 = 0;
    step3(1'b1, 8'h01, 1'b1);
    step3(1'b1, 8'h80, 1'b1);
    step3(1'b0, 8'h00, 1'b1);
    check("b2b_beats", beats3, 2);
    step3(1'b0, 8'h00, 1'b1);
    check("b2b_idle", b3.out_valid, 1'b0);
    $display("word3 back-to-back 01,80 beats=%0d", beats3);

    // Reset in the middle of 0xF0, after beat index 5
    step3(1'b1, 8'hF0, 1'b1);
    step3(1'b0, 8'h00, 1'b1);
    step3(1'b0, 8'h00, 1'b1);
    check("pre_reset_valid", b3.out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("reset_mid_word",
          {b3.out_valid, b3.in_ready, b3.out_index, b3.out_rank, b3.out_last, b3.out_empty},
          {1'b0, 1'b1, 3'd0, 4'd0, 1'b1, 1'b1});
    q3.delete();
    stall3 = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_word3(8'h02, beats, lrank, cycles);
    check("post_reset_beats", beats, 1);
    check("post_reset_rank", lrank, 1);
    $display("word3 after reset data=02 beats=%0d last_rank=%0d", beats, lrank);
    check("sb3_empty", q3.size(), 0);

    // Random sweep on ORDER=4
    n = 0;
    while (done4 < 1000 && n < 40000) begin
      case ($urandom_range(0, 7))
        0:       d = 16'h0000;
        1, 2:    d = 16'($urandom & $urandom & $urandom);
        default: d = 16'($urandom);
      endcase
      step4($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0);
      n++;
    end
    check("random_words", done4 >= 1000, 1'b1);
    n = 0;
    while (q4.size() != 0 && n < 100) begin
      step4(1'b0, 16'h0000, 1'b1);
      n++;
    end
    check("sb4_drained", q4.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
